// File: rtl/pixel_proc_pipe.sv
// Frame-based pixel processor: bypass, invert, 3x3 Gaussian blur and threshold,
// with valid/ready on both sides and a single registered output stage.
//
// state  | meaning
// S_IDLE | waiting for start; no input accepted
// S_RUN  | frame in progress; leaves on handshake of the frame's last output
module pixel_proc_pipe #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_thresh,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_sof,
    output logic              o_out_eol,
    output logic              o_busy,
    output logic              o_frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = DATA_W + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        M_BYPASS = 2'b00,
        M_INVERT = 2'b01,
        M_BLUR   = 2'b10,
        M_THRESH = 2'b11
    } mode_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    mode_t             r_mode;
    logic [DATA_W-1:0] r_thresh;
    logic [CW-1:0]     r_in_col;
    logic [RW-1:0]     r_in_row;
    logic              r_in_done;
    logic              r_sof_pend;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_sof;
    logic              r_out_eol;
    logic              r_out_last;
    logic              r_frame_done;

    logic [DATA_W-1:0] r_lb0 [IMG_W];
    logic [DATA_W-1:0] r_lb1 [IMG_W];
    logic [DATA_W-1:0] r_top0, r_top1;
    logic [DATA_W-1:0] r_mid0, r_mid1;
    logic [DATA_W-1:0] r_bot0, r_bot1;

    logic              w_consume;
    logic              w_produce;
    logic              w_last_hs;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_win_ok;
    logic [DATA_W-1:0] w_lb0_rd;
    logic [DATA_W-1:0] w_lb1_rd;
    logic [SW-1:0]     w_sum;
    logic [DATA_W-1:0] w_pix;

    assign w_col_last = (r_in_col == COL_LAST);
    assign w_row_last = (r_in_row == ROW_LAST);
    assign w_win_ok   = (r_in_row >= RW'(2)) && (r_in_col >= CW'(2));
    assign w_consume  = i_in_valid && o_in_ready;
    assign w_produce  = w_consume && ((r_mode != M_BLUR) || w_win_ok);
    assign w_last_hs  = r_out_valid && i_out_ready && r_out_last;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_in_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                o_busy     = 1'b1;
                o_in_ready = !r_in_done && (!r_out_valid || i_out_ready);
                if (w_last_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Window columns c-2, c-1 come from the tap registers; column c is read live.
    assign w_lb0_rd = r_lb0[r_in_col];
    assign w_lb1_rd = r_lb1[r_in_col];

    assign w_sum = SW'(r_top0)          + (SW'(r_top1) << 1)   + SW'(w_lb1_rd)
                 + (SW'(r_mid0) << 1)   + (SW'(r_mid1) << 2)   + (SW'(w_lb0_rd) << 1)
                 + SW'(r_bot0)          + (SW'(r_bot1) << 1)   + SW'(i_in_data);

    always_comb begin
        w_pix = i_in_data;
        case (r_mode)
            M_BYPASS: w_pix = i_in_data;
            M_INVERT: w_pix = ~i_in_data;
            M_BLUR:   w_pix = w_sum[SW-1:4];
            M_THRESH: w_pix = (i_in_data >= r_thresh) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            default:  w_pix = i_in_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mode       <= M_BYPASS;
            r_thresh     <= '0;
            r_in_col     <= '0;
            r_in_row     <= '0;
            r_in_done    <= 1'b0;
            r_sof_pend   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_sof    <= 1'b0;
            r_out_eol    <= 1'b0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last_hs;

            if ((r_state == S_IDLE) && i_start) begin
                r_mode     <= mode_t'(i_mode);
                r_thresh   <= i_thresh;
                r_in_col   <= '0;
                r_in_row   <= '0;
                r_in_done  <= 1'b0;
                r_sof_pend <= 1'b1;
            end else if (w_consume) begin
                if (w_col_last) begin
                    r_in_col <= '0;
                    if (w_row_last) begin
                        r_in_done <= 1'b1;
                    end else begin
                        r_in_row <= r_in_row + RW'(1);
                    end
                end else begin
                    r_in_col <= r_in_col + CW'(1);
                end
            end

            if (w_produce) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_pix;
                r_out_sof   <= r_sof_pend;
                r_out_eol   <= w_col_last;
                r_out_last  <= w_col_last && w_row_last;
                r_sof_pend  <= 1'b0;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Line buffers and window taps carry data only, so they are left unreset.
    always_ff @(posedge clk) begin
        if (w_consume) begin
            r_lb1[r_in_col] <= w_lb0_rd;
            r_lb0[r_in_col] <= i_in_data;
            r_top0          <= r_top1;
            r_top1          <= w_lb1_rd;
            r_mid0          <= r_mid1;
            r_mid1          <= w_lb0_rd;
            r_bot0          <= r_bot1;
            r_bot1          <= i_in_data;
        end
    end

    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_out_sof    = r_out_sof;
    assign o_out_eol    = r_out_eol;
    assign o_frame_done = r_frame_done;

endmodule
